// File: rtl/game_pkg.sv
// Shared game definitions: map defaults, tile encoding, match FSM states and the starting map.
package game_pkg;

    localparam int DEF_MAP_W = 20;
    localparam int DEF_MAP_H = 15;

    localparam logic [1:0] TILE_EMPTY = 2'd0;
    localparam logic [1:0] TILE_STEEL = 2'd1;
    localparam logic [1:0] TILE_BRICK = 2'd2;

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;

    typedef logic [DEF_MAP_W*DEF_MAP_H-1:0][1:0] tile_map_t;

    // Steel border, brick interior; the two tank spawn tiles stay open.
    function automatic logic [1:0] init_tile(int x, int y, int w, int h);
        if (x == 0 || y == 0 || x == w - 1 || y == h - 1) return TILE_STEEL;
        if ((x == 1 && y == h - 2) || (x == w - 2 && y == 1)) return TILE_EMPTY;
        return TILE_BRICK;
    endfunction

    function automatic tile_map_t build_init_map();
        tile_map_t m;
        for (int i = 0; i < DEF_MAP_W * DEF_MAP_H; i++) begin
            m[i] = init_tile(i % DEF_MAP_W, i / DEF_MAP_W, DEF_MAP_W, DEF_MAP_H);
        end
        return m;
    endfunction

    localparam tile_map_t INIT_MAP = build_init_map();

endpackage

// File: rtl/frame_timer.sv
// Frame down-counter for the post-hit freeze: load a start value, count to zero, flag done.
module frame_timer #(
    parameter int WIDTH = 6
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/map_keeper.sv
// Match keeper: owns the destructible tile map, resolves bullets against bricks and tanks,
// keeps scores and sequences rounds through IDLE/PLAY/PAUSE/OVER.
module map_keeper
    import game_pkg::*;
#(
    parameter int MAP_W        = DEF_MAP_W,
    parameter int MAP_H        = DEF_MAP_H,
    parameter int WIN_SCORE    = 5,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  int         Tank1X,
    input  int         Tank1Y,
    input  int         Tank2X,
    input  int         Tank2Y,
    input  int         Bul1X,
    input  int         Bul1Y,
    input  int         Bul2X,
    input  int         Bul2Y,
    output int         map [MAP_W*MAP_H],
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       round_reset,
    output logic [1:0] winner
);

    localparam int N     = MAP_W * MAP_H;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(PAUSE_FRAMES + 1);

    typedef logic [N-1:0][1:0] map_vec_t;

    function automatic map_vec_t build_map();
        map_vec_t m;
        for (int i = 0; i < N; i++) begin
            m[i] = init_tile(i % MAP_W, i / MAP_W, MAP_W, MAP_H);
        end
        return m;
    endfunction

    localparam map_vec_t START_MAP = build_map();

    function automatic logic in_map(int x, int y);
        return x >= 0 && y >= 0 && x < MAP_W && y < MAP_H;
    endfunction

    state_t           state_q, state_d;
    map_vec_t         map_q;
    logic [3:0]       score1_q, score2_q;
    logic [1:0]       winner_q;
    logic             b1_ok, b2_ok, hit1, hit2, brick1, brick2, won1, won2, timer_done;
    logic [IDX_W-1:0] idx1, idx2;

    assign b1_ok  = in_map(Bul1X, Bul1Y);
    assign b2_ok  = in_map(Bul2X, Bul2Y);
    // Off-map bullets index tile 0 but are masked by b*_ok, so no out-of-range reads.
    assign idx1   = b1_ok ? IDX_W'(Bul1Y * MAP_W + Bul1X) : '0;
    assign idx2   = b2_ok ? IDX_W'(Bul2Y * MAP_W + Bul2X) : '0;
    assign brick1 = b1_ok && map_q[idx1] == TILE_BRICK;
    assign brick2 = b2_ok && map_q[idx2] == TILE_BRICK;
    assign hit1   = b1_ok && Bul1X == Tank2X && Bul1Y == Tank2Y;
    assign hit2   = b2_ok && Bul2X == Tank1X && Bul2Y == Tank1Y;
    assign won1   = int'(score1_q) >= WIN_SCORE;
    assign won2   = int'(score2_q) >= WIN_SCORE;

    frame_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (state_q == PLAY && (hit1 || hit2)),
        .en        (state_q == PAUSE),
        .load_val  (CNT_W'(PAUSE_FRAMES - 1)),
        .done      (timer_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PLAY;
            PLAY:    if (hit1 || hit2) state_d = PAUSE;
            PAUSE:   if (timer_done) state_d = (won1 || won2) ? OVER : PLAY;
            OVER:    if (start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            map_q    <= START_MAP;
            score1_q <= '0;
            score2_q <= '0;
            winner_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                PLAY: begin
                    if (brick1) map_q[idx1] <= TILE_EMPTY;
                    if (brick2) map_q[idx2] <= TILE_EMPTY;
                    if (hit1 && score1_q != 4'hf) score1_q <= score1_q + 4'd1;
                    if (hit2 && score2_q != 4'hf) score2_q <= score2_q + 4'd1;
                end
                PAUSE: if (timer_done && (won1 || won2)) winner_q <= {won2, won1};
                OVER: if (start) begin
                    map_q    <= START_MAP;
                    score1_q <= '0;
                    score2_q <= '0;
                    winner_q <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            map[i] = {30'd0, map_q[i]};
        end
    end

    assign score1      = score1_q;
    assign score2      = score2_q;
    assign winner      = winner_q;
    assign round_reset = (state_q != PLAY);

endmodule

// File: doc/map_keeper.md
MAP_KEEPER -- requirements
Module: map_keeper

Interface
REQ-001 SHALL have parameter MAP_W, default 20, tiles per map row.
REQ-002 SHALL have parameter MAP_H, default 15, tile rows per map.
REQ-003 SHALL have parameter WIN_SCORE, default 5, hits needed to win a match.
REQ-004 SHALL have parameter PAUSE_FRAMES, default 60, frames frozen after a hit.
REQ-005 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port frame_clk, input, 1, clock; one edge per video frame.
REQ-007 SHALL have port start, input, 1, start/restart request, level-sampled.
REQ-008 SHALL have ports Tank1X, Tank1Y, Tank2X, Tank2Y, input, int each, tank tile coordinates.
REQ-009 SHALL have ports Bul1X, Bul1Y, Bul2X, Bul2Y, input, int each, bullet tile coordinates; -1 means no bullet.
REQ-010 SHALL have port map, output, int[MAP_W*MAP_H], tile array, index = Y*MAP_W + X; 0 empty, 1 steel, 2 brick.
REQ-011 SHALL have ports score1 and score2, output, 4 bits each, match hit counts.
REQ-012 SHALL have port round_reset, output, 1, drives both tank Reset inputs.
REQ-013 SHALL have port winner, output, 2 bits: 0 none, 1 player 1, 2 player 2, 3 draw.

Function
REQ-014 SHALL implement FSM states IDLE, PLAY, PAUSE, OVER.
REQ-015 IDLE SHALL assert round_reset and SHALL move to PLAY on the first edge with start=1.
REQ-016 PLAY SHALL deassert round_reset and SHALL resolve both bullets on every edge.
REQ-017 A bullet SHALL be ignored when either coordinate is negative, X>=MAP_W, or Y>=MAP_H.
REQ-018 A bullet on a brick tile SHALL set that tile to 0, visible on map at the next edge.
REQ-019 A bullet on a steel or empty tile SHALL leave map unchanged.
REQ-020 Both bullets on the same brick SHALL clear it once, with no error.
REQ-021 Bul1 equal to (Tank2X, Tank2Y) SHALL increment score1; Bul2 equal to (Tank1X, Tank1Y) SHALL increment score2.
REQ-022 Scores SHALL saturate at 15.
REQ-023 Any hit SHALL move PLAY to PAUSE on the same edge that updates the score.
REQ-024 Simultaneous hits SHALL increment both scores on the same edge.
REQ-025 PAUSE SHALL assert round_reset, SHALL load the frame counter with PAUSE_FRAMES-1, and SHALL count down once per edge.
REQ-026 When the counter reaches 0, PAUSE SHALL go to OVER if either score >= WIN_SCORE, else to PLAY.
REQ-027 On entry to OVER, winner SHALL be set to 1, 2, or 3 (both scores >= WIN_SCORE).
REQ-028 OVER SHALL hold round_reset=1.
REQ-029 OVER with start=1 SHALL clear the scores, clear winner, reload INIT_MAP, and go to IDLE.
REQ-030 Hit and brick resolution SHALL occur only in PLAY; start SHALL be ignored in PLAY and PAUSE.
REQ-031 Destroyed bricks SHALL persist across rounds until the match restarts.

Reset
REQ-032 On Reset: map=INIT_MAP, score1=score2=0, winner=0, round_reset=1, state=IDLE, counter=0.
REQ-033 Reset asserted mid-PAUSE or mid-PLAY SHALL abort immediately; no partial score or map update SHALL survive.

Structure
REQ-034 Shared package game_pkg SHALL hold MAP_W/MAP_H defaults, tile constants TILE_EMPTY/TILE_STEEL/TILE_BRICK, the FSM state enum, and the INIT_MAP constant (steel border, interior bricks, tank spawns (1,13) and (18,1) empty).
REQ-035 The pause countdown SHALL be a sub-module frame_timer (load, count-down, done flag).

Verification
REQ-036 Reset, start=1 one edge -> state PLAY, round_reset=0, map==INIT_MAP.
REQ-037 PLAY, Bul1 on a brick at (5,5) -> map[105]=0 next edge; scores unchanged.
REQ-038 PLAY, Bul2=(1,13) while Tank1 is at (1,13) -> score2=1, round_reset=1 for exactly 60 edges, then PLAY.
REQ-039 Both bullets hit their opposing tanks on the same edge with scores 4/4 -> scores 5/5; after the pause, OVER with winner=3.
REQ-040 Bullets at (-1,-1), (20,3), and on steel (0,0) -> map and scores unchanged.
REQ-041 Reset asserted during PAUSE at count 30 -> IDLE with scores 0 and map==INIT_MAP.
